// File: rtl/pattern_merge_pipe.sv
// Per-bit three-operand merge feeding a DEPTH-stage valid/ready pipeline,
// with a running output signature and a saturating transfer counter.
module pattern_merge_pipe #(
    parameter int unsigned     W     = 8,
    parameter int unsigned     DEPTH = 2,
    parameter logic [W-1:0]    POLY  = 8'h1D
) (
    input  logic               blif_clk_net,
    input  logic               blif_reset_net,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [W-1:0]       in_c,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    input  logic               sig_clear,
    output logic [W-1:0]       sig,
    output logic [15:0]        xfer_count
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] load;
    logic [W-1:0]     merged;
    logic             accept;
    logic             xfer;
    logic [W-1:0]     sig_q;
    logic [W-1:0]     sig_d;
    logic [W-1:0]     sig_base;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [15:0]      cnt_base;

    always_comb begin
        merged = '0;
        unique case (mode)
            2'd0: merged = in_a & in_b;
            2'd1: merged = in_a & in_b & ~in_c;
            2'd2: merged = ~(in_a | in_b) & ~in_c;
            2'd3: merged = in_a ^ in_b ^ in_c;
            default: merged = '0;
        endcase
    end

    // A stage can load whenever any stage from it to the output has a hole,
    // or the output side is draining; this is the bubble-collapsing chain.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            load[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                load[i] = load[i] | ~valid_q[j];
            end
        end
    end

    assign in_ready = load[0] & ~blif_reset_net;
    assign accept   = in_valid & in_ready;
    assign xfer     = valid_q[DEPTH-1] & out_ready & ~blif_reset_net;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (load[0]) begin
            valid_d[0] = accept;
            if (accept) data_d[0] = merged;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) data_d[i] = data_q[i-1];
            end
        end
    end

    always_comb begin
        sig_base = sig_clear ? '0 : sig_q;
        cnt_base = sig_clear ? '0 : cnt_q;
        sig_d    = sig_base;
        cnt_d    = cnt_base;
        if (xfer) begin
            sig_d = {sig_base[W-2:0], 1'b0} ^ (sig_base[W-1] ? POLY : '0) ^ data_q[DEPTH-1];
            cnt_d = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
        end
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            valid_q <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid  = valid_q[DEPTH-1];
    assign out_data   = data_q[DEPTH-1];
    assign sig        = sig_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Directed bench for pattern_merge_pipe at W=8, DEPTH=2, POLY=0x1D.
module tb_pattern_merge_pipe;

    logic        clk;
    logic        rst;
    logic [7:0]  a, b, c;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        sig_clear;
    logic [7:0]  sig;
    logic [15:0] xfer_count;

    int vectors = 0;
    int miscompares = 0;

    pattern_merge_pipe #(.W(8), .DEPTH(2), .POLY(8'h1D)) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .in_a           (a),
        .in_b           (b),
        .in_c           (c),
        .mode           (mode),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .sig_clear      (sig_clear),
        .sig            (sig),
        .xfer_count     (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] vc);
        mode = m; a = va; b = vb; c = vc; in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; sig_clear = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        mode = 2'($urandom); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);

        // reset with random inputs
        tick();
        #1 check("rst_in_ready", in_ready, 0);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_sig", sig, 8'h00);
        check("rst_count", xfer_count, 0);
        check("rst_in_ready2", in_ready, 0);

        // one beat per mode, streaming
        rst = 1'b0; sig_clear = 1'b0; out_ready = 1'b1;
        beat(2'd0, 8'hF0, 8'h3C, 8'h00);
        #1 check("first_in_ready", in_ready, 1);
        tick();
        check("mode_lat_valid", out_valid, 0);
        beat(2'd1, 8'hFF, 8'h0F, 8'h05);
        tick();
        check("mode0_valid", out_valid, 1);
        check("mode0", out_data, 8'h30);
        beat(2'd2, 8'h0F, 8'h30, 8'h80);
        tick();
        check("mode1", out_data, 8'h0A);
        beat(2'd3, 8'h0F, 8'h33, 8'h55);
        tick();
        check("mode2", out_data, 8'h40);
        in_valid = 1'b0; mode = 2'd0;
        tick();
        check("mode3", out_data, 8'h69);
        tick();
        check("mode_drain_valid", out_valid, 0);
        check("mode_count", xfer_count, 4);
        check("mode_sig", sig, 8'h5C);

        // backpressure
        out_ready = 1'b0;
        beat(2'd3, 8'h01, 8'h00, 8'h00);
        #1 check("bp_ready0", in_ready, 1);
        tick();
        beat(2'd3, 8'h02, 8'h00, 8'h00);
        #1 check("bp_ready1", in_ready, 1);
        tick();
        check("bp_head_valid", out_valid, 1);
        check("bp_head", out_data, 8'h01);
        beat(2'd3, 8'h03, 8'h00, 8'h00);
        #1 check("bp_full_ready", in_ready, 0);
        tick();
        check("bp_hold", out_data, 8'h01);
        check("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_out2", out_data, 8'h02);
        tick();
        check("bp_out3", out_data, 8'h03);
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_count", xfer_count, 7);

        // signature from clear
        sig_clear = 1'b1;
        tick();
        sig_clear = 1'b0;
        check("clr_sig", sig, 8'h00);
        check("clr_count", xfer_count, 0);
        beat(2'd3, 8'h80, 8'h00, 8'h00);
        tick();
        beat(2'd3, 8'h01, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        check("sig_80", sig, 8'h80);
        tick();
        check("sig_1C", sig, 8'h1C);
        check("sig_count", xfer_count, 2);

        // clear colliding with a transfer
        out_ready = 1'b0;
        beat(2'd3, 8'h55, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        check("coll_head", out_data, 8'h55);
        out_ready = 1'b1; sig_clear = 1'b1;
        tick();
        sig_clear = 1'b0;
        check("coll_sig", sig, 8'h55);
        check("coll_count", xfer_count, 1);

        // reset with two beats in flight
        out_ready = 1'b0;
        beat(2'd3, 8'hAA, 8'h00, 8'h00);
        tick();
        beat(2'd3, 8'hBB, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        check("mid_full", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_count", xfer_count, 0);
        rst = 1'b0; out_ready = 1'b1;
        #1 check("mid_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_ghost", out_valid, 0);
        end
        check("mid_count_after", xfer_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
